// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from the segment and digit-select lines of a multiplexed
// 4-digit 7-segment display, with input debouncing, per-digit staleness and frame tracking.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_en,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_valid,
  output logic [3:0]  seg_err,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       valid;
    logic       err;
  } decode_t;

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_AGE = 16'(TIMEOUT);
  localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

  // Blank (all segments off) is not an error; anything outside the table is.
  function automatic decode_t decode(input logic [6:0] s);
    decode_t d;
    d = '{value: 4'hF, valid: 1'b0, err: 1'b1};
    case (s)
      7'b1111110: d = '{value: 4'd0, valid: 1'b1, err: 1'b0};
      7'b0110000: d = '{value: 4'd1, valid: 1'b1, err: 1'b0};
      7'b1101101: d = '{value: 4'd2, valid: 1'b1, err: 1'b0};
      7'b1111001: d = '{value: 4'd3, valid: 1'b1, err: 1'b0};
      7'b0110011: d = '{value: 4'd4, valid: 1'b1, err: 1'b0};
      7'b1011011: d = '{value: 4'd5, valid: 1'b1, err: 1'b0};
      7'b1011111: d = '{value: 4'd6, valid: 1'b1, err: 1'b0};
      7'b1110000: d = '{value: 4'd7, valid: 1'b1, err: 1'b0};
      7'b1111111: d = '{value: 4'd8, valid: 1'b1, err: 1'b0};
      7'b1111011: d = '{value: 4'd9, valid: 1'b1, err: 1'b0};
      7'b0000000: d.err = 1'b0;
      default:    ;
    endcase
    return d;
  endfunction

  logic [6:0]  seg_r, seg_l, seg_l_next;
  logic [3:0]  en_r, en_l, en_l_next;
  state_t      state, state_next;
  logic [7:0]  count, count_next;
  logic        commit;
  logic        one_hot;
  logic        changed;
  decode_t     dec;
  logic [3:0]  mask;
  logic [15:0] age     [4];
  logic [15:0] age_inc [4];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= '0;
      en_r  <= '0;
    end else begin
      seg_r <= seg;
      en_r  <= dig_en;
    end
  end

  assign one_hot = $onehot(en_r);
  assign changed = (seg_r != seg_l) || (en_r != en_l);
  assign dec     = decode(seg_l);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    count_next = count;
    seg_l_next = seg_l;
    en_l_next  = en_l;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (one_hot) begin
          state_next = SETTLE;
          count_next = 8'd1;
          seg_l_next = seg_r;
          en_l_next  = en_r;
        end
      end
      SETTLE, HOLD: begin
        if (changed) begin
          if (one_hot) begin
            state_next = SETTLE;
            count_next = 8'd1;
            seg_l_next = seg_r;
            en_l_next  = en_r;
          end else begin
            state_next = IDLE;
            count_next = 8'd0;
          end
        end else if (state == SETTLE) begin
          count_next = count + 8'd1;
          if (count_next == STABLE_LAST) begin
            commit     = 1'b1;
            state_next = HOLD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      seg_l <= '0;
      en_l  <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      seg_l <= seg_l_next;
      en_l  <= en_l_next;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      age_inc[i] = (age[i] == 16'hFFFF) ? age[i] : age[i] + 16'd1;
    end
  end

  // A commit to digit i outranks its own timeout on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_out     <= 16'hFFFF;
      digit_valid <= '0;
      seg_err     <= '0;
      frame_done  <= 1'b0;
      mask        <= '0;
      // NOTE: the age array is reset as well, since its contents drive the timeout compare.
      for (int i = 0; i < 4; i++) age[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (commit && en_l[i]) begin
          age[i]            <= '0;
          bcd_out[4*i +: 4] <= dec.value;
          digit_valid[i]    <= dec.valid;
          seg_err[i]        <= dec.err;
        end else begin
          age[i] <= age_inc[i];
          if (TIMEOUT_EN && (age_inc[i] == TIMEOUT_AGE)) begin
            bcd_out[4*i +: 4] <= 4'hF;
            digit_valid[i]    <= 1'b0;
            seg_err[i]        <= 1'b0;
          end
        end
      end
      if (commit) begin
        if ((mask | en_l) == 4'hF) begin
          frame_done <= 1'b1;
          mask       <= '0;
        end else begin
          mask <= mask | en_l;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized scanning checked
// against a run-length reference model, on a long-timeout and a 20-cycle-timeout instance.
module tb_seg7_scan_decoder;

  localparam int S       = 4;
  localparam int T_LONG  = 50000;
  localparam int T_SHORT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] bcd_a, bcd_b;
  logic [3:0]  val_a, val_b, err_a, err_b;
  logic        fd_a, fd_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT(T_LONG)) dut (
    .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
    .bcd_out(bcd_a), .digit_valid(val_a), .seg_err(err_a), .frame_done(fd_a)
  );

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT(T_SHORT)) dut_to (
    .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
    .bcd_out(bcd_b), .digit_valid(val_b), .seg_err(err_b), .frame_done(fd_b)
  );

  logic [6:0] legal [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model: a digit commits when the registered {dig_en, seg} has held the
  // same one-hot value for exactly S samples; ages are edges since last commit or reset.
  int          timeouts [2] = '{T_LONG, T_SHORT};
  int          cyc = 0;
  logic [10:0] reg_key, run_key;
  int          run_len;
  int          last_ev [4];
  logic [3:0]  m_nib [2][4];
  logic        m_val [2][4];
  logic        m_err [2][4];
  logic        m_fd;
  logic [3:0]  m_mask;
  int          cd;
  logic [3:0]  c_nib;
  logic        c_ok, c_er;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      reg_key = '0; run_key = '0; run_len = 0; m_fd = 1'b0; m_mask = '0;
      for (int i = 0; i < 4; i++) begin
        last_ev[i] = cyc;
        for (int n = 0; n < 2; n++) begin
          m_nib[n][i] = 4'hF; m_val[n][i] = 1'b0; m_err[n][i] = 1'b0;
        end
      end
    end else begin
      if (reg_key == run_key) run_len++;
      else begin run_key = reg_key; run_len = 1; end
      cd = -1;
      if ($countones(run_key[10:7]) == 1 && run_len == S)
        for (int i = 0; i < 4; i++) if (run_key[7+i]) cd = i;
      c_nib = 4'hF; c_ok = 1'b0; c_er = (run_key[6:0] != 7'd0);
      for (int j = 0; j < 10; j++)
        if (legal[j] == run_key[6:0]) begin c_nib = 4'(j); c_ok = 1'b1; c_er = 1'b0; end
      m_fd = 1'b0;
      for (int n = 0; n < 2; n++)
        for (int i = 0; i < 4; i++)
          if (i == cd) begin
            m_nib[n][i] = c_nib; m_val[n][i] = c_ok; m_err[n][i] = c_er;
          end else if (timeouts[n] != 0 && cyc - last_ev[i] == timeouts[n]) begin
            m_nib[n][i] = 4'hF; m_val[n][i] = 1'b0; m_err[n][i] = 1'b0;
          end
      if (cd >= 0) begin
        last_ev[cd] = cyc;
        m_mask[cd]  = 1'b1;
        if (m_mask == 4'hF) begin m_fd = 1'b1; m_mask = '0; end
      end
      reg_key = {dig_en, seg};
    end
  end

  function automatic logic [24:0] exp_vec(input int n);
    logic [24:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[9+4*i +: 4] = m_nib[n][i];
      v[5+i]        = m_val[n][i];
      v[1+i]        = m_err[n][i];
    end
    v[0] = m_fd;
    return v;
  endfunction

  task automatic drive(input logic [3:0] e, input logic [6:0] s);
    dig_en = e;
    seg    = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(4'($urandom), 7'($urandom));
    repeat (3) @(negedge clk);
    vectors++;
    if ({bcd_a, val_a, err_a, fd_a} !== {16'hFFFF, 4'h0, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_a: got %h_%b_%b_%b want ffff_0000_0000_0", bcd_a, val_a, err_a, fd_a);
    end
    vectors++;
    if ({bcd_b, val_b, err_b, fd_b} !== {16'hFFFF, 4'h0, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_b: got %h_%b_%b_%b want ffff_0000_0000_0", bcd_b, val_b, err_b, fd_b);
    end
    rst = 1'b0;
    drive(4'h0, 7'h0);
    @(negedge clk);
    vectors++;
    if ({bcd_a, val_a, err_a, fd_a} !== {16'hFFFF, 4'h0, 4'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_release: got %h_%b_%b_%b want ffff_0000_0000_0", bcd_a, val_a, err_a, fd_a);
    end
  endtask

  task automatic test_basic_commit;
    @(negedge clk);
    drive(4'b0001, 7'b1101101);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if ({bcd_a[3:0], val_a} !== ((k >= S) ? {4'd2, 4'b0001} : {4'hF, 4'b0000})) begin
        miscompares++;
        $display("FAIL basic_commit edge+%0d: got nib=%h valid=%b want %s", k, bcd_a[3:0], val_a,
                 (k >= S) ? "2/0001" : "f/0000");
      end
    end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    drive(4'b0100, 7'b1111001);
    repeat (3) @(negedge clk);
    drive(4'b0100, 7'b0110011);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if ({bcd_a[11:8], val_a[2]} !== ((k >= S) ? {4'd4, 1'b1} : {4'hF, 1'b0})) begin
        miscompares++;
        $display("FAIL glitch edge+%0d: got nib=%h valid=%b want %s", k, bcd_a[11:8], val_a[2],
                 (k >= S) ? "4/1" : "f/0");
      end
    end
  endtask

  task automatic test_frame;
    int pulses;
    pulses = 0;
    @(negedge clk);
    rst = 1'b1;
    drive(4'h0, 7'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 4; d++) begin
      drive(4'b0001 << d, legal[d]);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        pulses += int'(fd_a);
        vectors++;
        if (fd_a !== (d == 3 && k == S)) begin
          miscompares++;
          $display("FAIL frame_pulse digit=%0d edge+%0d: got %b want %b", d, k, fd_a, (d == 3 && k == S));
        end
      end
    end
    vectors++;
    if ({bcd_a, val_a} !== {16'h3210, 4'hF}) begin
      miscompares++;
      $display("FAIL frame_value: got %h/%b want 3210/1111", bcd_a, val_a);
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL frame_count: got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_errors;
    drive(4'b0010, 7'b1000001);
    repeat (6) @(negedge clk);
    vectors++;
    if ({err_a, bcd_a[7:4], val_a} !== {4'b0010, 4'hF, 4'b1101}) begin
      miscompares++;
      $display("FAIL illegal: got err=%b nib=%h valid=%b want 0010/f/1101", err_a, bcd_a[7:4], val_a);
    end
    drive(4'b0010, 7'b0000000);
    repeat (6) @(negedge clk);
    vectors++;
    if ({err_a, bcd_a[7:4], val_a} !== {4'b0000, 4'hF, 4'b1101}) begin
      miscompares++;
      $display("FAIL blank: got err=%b nib=%h valid=%b want 0000/f/1101", err_a, bcd_a[7:4], val_a);
    end
  endtask

  task automatic test_timeout;
    drive(4'b0001, 7'b1111110);
    repeat (S + 1) @(negedge clk);
    vectors++;
    if ({bcd_b[3:0], val_b[0]} !== {4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_commit: got nib=%h valid=%b want 0/1", bcd_b[3:0], val_b[0]);
    end
    drive(4'b0000, 7'b0000000);
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk);
      vectors++;
      if ({bcd_b[3:0], val_b[0]} !== ((j < T_SHORT) ? {4'd0, 1'b1} : {4'hF, 1'b0})) begin
        miscompares++;
        $display("FAIL timeout commit+%0d: got nib=%h valid=%b want %s", j, bcd_b[3:0], val_b[0],
                 (j < T_SHORT) ? "0/1" : "f/0");
      end
    end
    vectors++;
    if ({bcd_a[3:0], val_a[0]} !== {4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL long_timeout_hold: got nib=%h valid=%b want 0/1", bcd_a[3:0], val_a[0]);
    end
  endtask

  task automatic test_reset_mid_settle;
    drive(4'b0100, 7'b1011011);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({bcd_a, val_a, err_a, fd_a, bcd_b, val_b, err_b, fd_b} !==
          {16'hFFFF, 9'h0, 16'hFFFF, 9'h0}) begin
        miscompares++;
        $display("FAIL mid_settle_reset %0d: got %h/%b/%b %h/%b/%b want ffff/0000/0000", k,
                 bcd_a, val_a, err_a, bcd_b, val_b, err_b);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vectors++;
      if ({bcd_a[11:8], val_a[2]} !== ((k >= S) ? {4'd5, 1'b1} : {4'hF, 1'b0})) begin
        miscompares++;
        $display("FAIL mid_settle_requal edge+%0d: got nib=%h valid=%b want %s", k, bcd_a[11:8],
                 val_a[2], (k >= S) ? "5/1" : "f/0");
      end
    end
  endtask

  task automatic test_random(input int n);
    int         hold;
    int         r;
    logic [3:0] e;
    logic [6:0] s;
    hold = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      vectors++;
      if ({bcd_a, val_a, err_a, fd_a} !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL random_long cyc=%0d: got %h want %h", c, {bcd_a, val_a, err_a, fd_a}, exp_vec(0));
      end
      vectors++;
      if ({bcd_b, val_b, err_b, fd_b} !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL random_short cyc=%0d: got %h want %h", c, {bcd_b, val_b, err_b, fd_b}, exp_vec(1));
      end
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        e = 4'b0001 << $urandom_range(0, 3);
        s = legal[$urandom_range(0, 9)];
        case (r)
          6:       s = 7'h0;
          7:       s = 7'($urandom);
          8:       e = 4'h0;
          9:       e = 4'($urandom);
          default: ;
        endcase
        hold = (r == 8 && $urandom_range(0, 3) == 0) ? 25 : $urandom_range(1, 8);
        drive(e, s);
      end
      hold--;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'h0, 7'h0);
    test_reset;
    test_basic_commit;
    test_glitch;
    test_frame;
    test_errors;
    test_timeout;
    test_reset_mid_settle;
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
